// File: rtl/div_32_23_recon.sv
// Rebuilds a dividend X = Q*D + R from a quotient/remainder pair by shift-adding
// Q over the bits of the constant D, one bit per cycle, behind valid/ready handshakes.
module div_32_23_recon #(
  parameter int X_W = 32,
  parameter int Q_W = 28,
  parameter int R_W = 5,
  parameter int D   = 23
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [Q_W-1:0] Q_in,
  input  logic [R_W-1:0] R_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [X_W-1:0] X_out,
  output logic           err_rem,
  output logic           err_ovf
);

  localparam int ACC_W = X_W + 2;
  localparam int K_W   = (R_W > 1) ? $clog2(R_W) : 1;
  localparam logic [R_W-1:0] D_BITS = R_W'(D);
  localparam logic [K_W-1:0] K_INIT = K_W'(R_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [Q_W-1:0]   q_r;
  logic [ACC_W-1:0] acc_r;
  logic [K_W-1:0]   k_r;
  logic [ACC_W-1:0] q_ext_s;
  logic [ACC_W-1:0] acc_next_s;

  assign q_ext_s = {{(ACC_W-Q_W){1'b0}}, q_r};

  // Accumulator value after this cycle's conditional shift-add of Q.
  always_comb begin
    acc_next_s = acc_r;
    if (D_BITS[k_r]) begin
      acc_next_s = acc_r + (q_ext_s << k_r);
    end else begin
      acc_next_s = acc_r;
    end
  end

  // Handshake FSM, bit-serial datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      X_out     <= '0;
      err_rem   <= 1'b0;
      err_ovf   <= 1'b0;
      q_r       <= '0;
      acc_r     <= '0;
      k_r       <= K_INIT;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            q_r      <= Q_in;
            acc_r    <= {{(ACC_W-R_W){1'b0}}, R_in};
            err_rem  <= (R_in >= D_BITS);
            k_r      <= K_INIT;
            in_ready <= 1'b0;
            state_r  <= BUSY;
          end
        end
        BUSY: begin
          acc_r <= acc_next_s;
          if (k_r == {K_W{1'b0}}) begin
            // Last bit of D consumed: any carry above X_W means X does not fit.
            X_out     <= acc_next_s[X_W-1:0];
            err_ovf   <= |acc_next_s[ACC_W-1:X_W];
            out_valid <= 1'b1;
            state_r   <= DONE;
          end else begin
            k_r <= k_r - {{(K_W-1){1'b0}}, 1'b1};
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_r   <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule
